// File: rtl/seq_num_commit_ctrl.sv
// seq_num_commit_ctrl: frees allocated sequence numbers strictly in age order once each has completed.
module seq_num_commit_ctrl #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  input  logic                      alloc_rdy,
  input  logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      cmpl_val,
  input  logic [p_seq_num_bits-1:0] cmpl_seq_num,
  output logic                      free_val,
  output logic [p_seq_num_bits-1:0] free_seq_num,
  output logic [p_seq_num_bits:0]   count,
  output logic                      empty,
  output logic                      err
);
  localparam int D = 2 ** p_seq_num_bits;
  localparam logic [p_seq_num_bits:0] c_full = (p_seq_num_bits + 1)'(D);
  logic [D-1:0]                r_alloc, r_done, w_alloc_nxt, w_done_nxt;
  logic [p_seq_num_bits-1:0]   r_head, r_tail, r_free_seq_num;
  logic [p_seq_num_bits:0]     r_count;
  logic                        r_free_val, r_err;
  logic                        w_afire, w_alloc_ok, w_cmpl_ok, w_head_ready, w_illegal;
  assign w_afire      = alloc_val & alloc_rdy;
  assign w_alloc_ok   = w_afire & (alloc_seq_num == r_tail) & (r_count != c_full);
  // uses pre-edge state, so completing the entry allocated this cycle is an error
  assign w_cmpl_ok    = cmpl_val & r_alloc[cmpl_seq_num] & ~r_done[cmpl_seq_num];
  assign w_head_ready = r_alloc[r_head] & (r_done[r_head] | (cmpl_val & (cmpl_seq_num == r_head)));
  assign w_illegal    = (w_afire & ~w_alloc_ok) | (cmpl_val & ~w_cmpl_ok);
  always_comb begin
    w_alloc_nxt = r_alloc;
    w_done_nxt  = r_done;
    if (w_cmpl_ok) w_done_nxt[cmpl_seq_num] = 1'b1;
    if (w_alloc_ok) begin
      w_alloc_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]  = 1'b0;
    end
    // freeing last so a bypassed head completion leaves no stale done bit
    if (w_head_ready) begin
      w_alloc_nxt[r_head] = 1'b0;
      w_done_nxt[r_head]  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alloc        <= '0;
      r_done         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_free_val     <= 1'b0;
      r_free_seq_num <= '0;
      r_err          <= 1'b0;
    end else begin
      r_alloc    <= w_alloc_nxt;
      r_done     <= w_done_nxt;
      r_free_val <= w_head_ready;
      r_count    <= r_count + {{p_seq_num_bits{1'b0}}, w_alloc_ok} - {{p_seq_num_bits{1'b0}}, w_head_ready};
      if (w_alloc_ok) r_tail <= r_tail + 1'b1;
      if (w_head_ready) begin
        r_head         <= r_head + 1'b1;
        r_free_seq_num <= r_head;
      end
      if (w_illegal) r_err <= 1'b1;
    end
  end
  assign free_val     = r_free_val;
  assign free_seq_num = r_free_seq_num;
  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign err          = r_err;
endmodule

// File: tb/tb_seq_num_commit_ctrl.sv
// tb_seq_num_commit_ctrl: directed scenarios checked against an age-ordered reference scoreboard.
module tb_seq_num_commit_ctrl;
  localparam int W = 5;
  localparam int D = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic alloc_val = 1'b0, alloc_rdy = 1'b0, cmpl_val = 1'b0;
  logic [W-1:0] alloc_seq_num = '0, cmpl_seq_num = '0;
  logic free_val, empty, err;
  logic [W-1:0] free_seq_num;
  logic [W:0] count;
  seq_num_commit_ctrl #(.p_seq_num_bits(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_seq_num(alloc_seq_num),
    .cmpl_val(cmpl_val), .cmpl_seq_num(cmpl_seq_num),
    .free_val(free_val), .free_seq_num(free_seq_num),
    .count(count), .empty(empty), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic         fv;
    logic [W-1:0] fs;
    logic [W:0]   cnt;
    logic         er;
  } exp_t;
  exp_t sb[$];
  int pend[$];
  bit m_alloc[D];
  bit m_done[D];
  int m_tail = 0;
  bit m_err = 1'b0;
  logic [W-1:0] m_fs = '0;
  int checks = 0;
  int errors = 0;
  string step = "init";
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit rn, input bit av, input bit ar, input int as, input bit cv, input int cs);
    exp_t e;
    bit afire, aok, cok, hr;
    int f;
    rst = rn; alloc_val = av; alloc_rdy = ar; alloc_seq_num = W'(as);
    cmpl_val = cv; cmpl_seq_num = W'(cs);
    e = '0;
    if (!rn) begin
      pend.delete();
      foreach (m_alloc[i]) begin m_alloc[i] = 0; m_done[i] = 0; end
      m_tail = 0; m_err = 0; m_fs = '0;
    end else begin
      afire = av && ar;
      aok   = afire && as == m_tail && pend.size() < D;
      cok   = cv && m_alloc[cs] && !m_done[cs];
      if ((afire && !aok) || (cv && !cok)) m_err = 1;
      hr = pend.size() > 0 && (m_done[pend[0]] || (cv && cs == pend[0]));
      if (cok) m_done[cs] = 1;
      if (aok) begin
        pend.push_back(as); m_alloc[as] = 1; m_done[as] = 0; m_tail = (m_tail + 1) % D;
      end
      if (hr) begin
        f = pend.pop_front(); m_alloc[f] = 0; m_done[f] = 0; m_fs = W'(f);
      end
      e.fv = hr;
    end
    e.fs = m_fs; e.cnt = (W+1)'(pend.size()); e.er = m_err;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("free_val", 32'(free_val), 32'(e.fv));
    chk("free_seq_num", 32'(free_seq_num), 32'(e.fs));
    chk("count", 32'(count), 32'(e.cnt));
    chk("empty", 32'(empty), 32'(e.cnt == 0));
    chk("err", 32'(err), 32'(e.er));
  endtask
  task automatic reset_c(); cyc(0, 1, 1, 3, 1, 3); endtask
  task automatic alloc(input int n); cyc(1, 1, 1, n, 0, 0); endtask
  task automatic cmpl(input int n); cyc(1, 0, 0, 0, 1, n); endtask
  task automatic idle(); cyc(1, 0, 0, 0, 0, 0); endtask
  initial begin
    step = "reset";
    reset_c();
    chk("rst_empty", 32'(empty), 1); chk("rst_err", 32'(err), 0);
    step = "basic";
    alloc(0); alloc(1);
    chk("count2", 32'(count), 2);
    cyc(1, 1, 0, 7, 0, 0);
    cmpl(0);
    chk("free0_val", 32'(free_val), 1); chk("free0_seq", 32'(free_seq_num), 0); chk("count1", 32'(count), 1);
    idle(); idle();
    cmpl(1);
    chk("free1_seq", 32'(free_seq_num), 1); chk("count0", 32'(count), 0); chk("empty0", 32'(empty), 1);
    idle();
    step = "ooo";
    reset_c();
    alloc(0); alloc(1); alloc(2);
    cmpl(2); cmpl(1);
    chk("no_free", 32'(free_val), 0);
    cmpl(0);
    chk("drain0", 32'(free_seq_num), 0);
    idle(); chk("drain1", 32'(free_seq_num), 1);
    idle(); chk("drain2", 32'(free_seq_num), 2); chk("ooo_err", 32'(err), 0);
    idle();
    step = "wrap";
    reset_c();
    for (int i = 0; i < D; i++) alloc(i);
    chk("full", 32'(count), 32);
    for (int i = 0; i < D; i++) cmpl(i);
    idle();
    alloc(0);
    chk("wrap_count", 32'(count), 1); chk("wrap_err", 32'(err), 0);
    step = "err_unalloc";
    reset_c(); alloc(0); cmpl(5);
    chk("e1", 32'(err), 1); chk("e1_count", 32'(count), 1);
    step = "err_seq";
    reset_c(); alloc(3);
    chk("e2", 32'(err), 1); chk("e2_count", 32'(count), 0);
    step = "err_full";
    reset_c();
    for (int i = 0; i < D; i++) alloc(i);
    alloc(0);
    chk("e3", 32'(err), 1); chk("e3_count", 32'(count), 32);
    step = "err_double";
    reset_c(); alloc(0); alloc(1); cmpl(1); cmpl(1);
    chk("e4", 32'(err), 1); chk("e4_free", 32'(free_val), 0);
    cmpl(0); idle(); idle();
    step = "same_cycle_alloc_cmpl";
    reset_c(); alloc(0); cyc(1, 1, 1, 1, 1, 1);
    chk("e5", 32'(err), 1); chk("e5_count", 32'(count), 2);
    step = "concurrency";
    reset_c();
    for (int i = 0; i < 4; i++) alloc(i);
    cyc(1, 1, 1, 4, 1, 0);
    chk("c_count", 32'(count), 4); chk("c_free", 32'(free_seq_num), 0);
    cyc(1, 1, 1, 5, 1, 1);
    chk("c2_count", 32'(count), 4); chk("c2_free", 32'(free_seq_num), 1); chk("c2_err", 32'(err), 0);
    cmpl(3); cmpl(2);
    idle(); idle();
    step = "mid_reset";
    reset_c();
    for (int i = 0; i < 4; i++) alloc(i);
    cmpl(2); cmpl(3);
    reset_c();
    chk("r_count", 32'(count), 0); chk("r_free", 32'(free_val), 0); chk("r_seq", 32'(free_seq_num), 0);
    for (int i = 0; i < 30; i++) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
